// File: rtl/music_sequencer.sv
// Background-music playback controller: steps the note ROM at a fixed tempo, synthesises a
// square wave from the held note and lets one-shot sound effects pre-empt the music output.
`timescale 1ns/1ps
module music_sequencer #(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int SONG_LEN       = 176,
    parameter int LOOP_START     = 8,
    parameter int SFX_TICKS      = 5_000_000,
    parameter int PHASE_W        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_pause,
    input  logic       loop_en,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_note,
    input  logic       sfx_req,
    input  logic [7:0] sfx_note,
    output logic       sfx_ack,
    output logic [7:0] cur_note,
    output logic       playing,
    output logic       song_done,
    output logic       audio_out,
    output logic       audio_en
);

    localparam int TICK_W = $clog2(TICKS_PER_STEP + 1);
    localparam int SFX_W  = $clog2(SFX_TICKS + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, PAUSED} state_t;

    state_t               state, state_nxt;
    logic [TICK_W-1:0]    tick_cnt;
    logic                 pause_pend;
    logic [PHASE_W-1:0]   phase, phase_nxt;
    logic [SFX_W-1:0]     sfx_cnt;
    logic                 sfx_active;
    logic [7:0]           sfx_latched;
    logic [7:0]           act_note;
    logic                 step_end, last_step, song_end;

    assign step_end  = (tick_cnt == TICK_W'(TICKS_PER_STEP - 1));
    assign last_step = (rom_addr >= 8'(SONG_LEN - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (cmd_stop)       state_nxt = IDLE;
        else if (cmd_start) state_nxt = FETCH;
        else begin
            case (state)
                IDLE:   state_nxt = IDLE;
                FETCH:  state_nxt = LOAD;
                LOAD:   state_nxt = PLAY;
                PLAY: begin
                    if (cmd_pause || pause_pend)   state_nxt = PAUSED;
                    else if (step_end)             state_nxt = (last_step && !loop_en) ? IDLE : FETCH;
                end
                PAUSED: if (cmd_pause) state_nxt = PLAY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        playing  = (state == FETCH) || (state == LOAD) || (state == PLAY);
        song_end = (state == PLAY) && (state_nxt == IDLE) && !cmd_stop;
        act_note = sfx_active ? sfx_latched : ((state == PLAY) ? cur_note : 8'd0);
        phase_nxt = phase;
        // SFX keeps the shared accumulator running; music alone freezes it while paused.
        if (sfx_active)              phase_nxt = phase + PHASE_W'(sfx_latched);
        else if (cmd_stop)           phase_nxt = '0;
        else if (state == PAUSED)    phase_nxt = phase;
        else if (act_note == 8'd0)   phase_nxt = '0;
        else                         phase_nxt = phase + PHASE_W'(act_note);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= 8'd0;
            cur_note   <= 8'd0;
            tick_cnt   <= '0;
            pause_pend <= 1'b0;
        end else if (cmd_stop || cmd_start) begin
            rom_addr   <= 8'd0;
            cur_note   <= 8'd0;
            tick_cnt   <= '0;
            pause_pend <= 1'b0;
        end else begin
            case (state)
                FETCH: if (cmd_pause) pause_pend <= !pause_pend;
                LOAD: begin
                    if (cmd_pause) pause_pend <= !pause_pend;
                    cur_note <= rom_note;
                    tick_cnt <= '0;
                end
                PLAY: begin
                    if (cmd_pause || pause_pend) begin
                        pause_pend <= 1'b0;
                    end else if (step_end) begin
                        tick_cnt <= '0;
                        cur_note <= 8'd0;
                        if (!last_step)   rom_addr <= rom_addr + 8'd1;
                        else if (loop_en) rom_addr <= 8'(LOOP_START);
                        else              rom_addr <= 8'd0;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new request always wins, so a retrigger reloads the note and the full duration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfx_latched <= 8'd0;
            sfx_cnt     <= '0;
            sfx_active  <= 1'b0;
            sfx_ack     <= 1'b0;
        end else begin
            sfx_ack <= sfx_req;
            if (sfx_req) begin
                sfx_latched <= sfx_note;
                sfx_cnt     <= SFX_W'(SFX_TICKS - 1);
                sfx_active  <= 1'b1;
            end else if (sfx_active) begin
                if (sfx_cnt == '0) sfx_active <= 1'b0;
                else               sfx_cnt    <= sfx_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            audio_out <= 1'b0;
            audio_en  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            audio_out <= phase_nxt[PHASE_W-1] & (act_note != 8'd0);
            audio_en  <= (act_note != 8'd0);
            song_done <= song_end;
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: small tempo, 12-entry song, ROM model mem[a]=a*3.
`timescale 1ns/1ps
module tb_music_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_start, cmd_stop, cmd_pause, loop_en;
    logic [7:0] rom_addr, rom_note;
    logic       sfx_req;
    logic [7:0] sfx_note;
    logic       sfx_ack;
    logic [7:0] cur_note;
    logic       playing, song_done, audio_out, audio_en;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] note;
    } step_t;

    step_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    ack_cnt  = 0;
    int    en_cnt   = 0;
    int    done_cnt = 0;

    music_sequencer #(
        .TICKS_PER_STEP(4),
        .SONG_LEN      (12),
        .LOOP_START    (8),
        .SFX_TICKS     (6),
        .PHASE_W       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_start(cmd_start),
        .cmd_stop (cmd_stop),
        .cmd_pause(cmd_pause),
        .loop_en  (loop_en),
        .rom_addr (rom_addr),
        .rom_note (rom_note),
        .sfx_req  (sfx_req),
        .sfx_note (sfx_note),
        .sfx_ack  (sfx_ack),
        .cur_note (cur_note),
        .playing  (playing),
        .song_done(song_done),
        .audio_out(audio_out),
        .audio_en (audio_en)
    );

    always #5 clk = ~clk;

    // Registered-read note ROM, one clock of latency.
    always_ff @(posedge clk) rom_note <= rom_addr * 8'd3;

    always @(negedge clk) begin
        if (sfx_ack)   ack_cnt  <= ack_cnt + 1;
        if (audio_en)  en_cnt   <= en_cnt + 1;
        if (song_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic start_song();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    initial begin
        step_t s;
        int    base_ack, base_en;

        rst_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_pause = 1'b0;
        loop_en = 1'b0; sfx_req = 1'b0; sfx_note = 8'd0;
        #12;
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_note", 32'(cur_note), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_audio_en", 32'(audio_en), 0);
        check("rst_audio_out", 32'(audio_out), 0);
        rst_n = 1'b1;

        // Full song without looping: each step held 6 clk, sampled in its second PLAY cycle.
        start_song();
        check("start_playing", 32'(playing), 1);
        for (int k = 0; k < 12; k++) exp_q.push_back('{addr: 8'(k), note: 8'(3 * k)});
        repeat (3) tick();
        for (int k = 0; k < 12; k++) begin
            s = exp_q.pop_front();
            check("song_addr", 32'(rom_addr), 32'(s.addr));
            check("song_note", 32'(cur_note), 32'(s.note));
            if (k < 11) repeat (6) tick();
        end
        repeat (3) tick();
        check("end_done", 32'(song_done), 1);
        check("end_playing", 32'(playing), 0);
        check("end_addr", 32'(rom_addr), 0);
        check("end_note", 32'(cur_note), 0);
        tick();
        check("end_done_pulse", 32'(song_done), 0);

        // Looping: after address 11 the song resumes from 8.
        loop_en = 1'b1;
        start_song();
        for (int k = 0; k < 17; k++) begin
            int a;
            a = (k < 12) ? k : 8 + (k - 12) % 4;
            exp_q.push_back('{addr: 8'(a), note: 8'(3 * a)});
        end
        repeat (3) tick();
        for (int k = 0; k < 17; k++) begin
            s = exp_q.pop_front();
            check("loop_addr", 32'(rom_addr), 32'(s.addr));
            check("loop_note", 32'(cur_note), 32'(s.note));
            if (k < 16) repeat (6) tick();
        end
        check("loop_no_done", 32'(done_cnt), 1);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("stop_playing", 32'(playing), 0);
        check("stop_addr", 32'(rom_addr), 0);
        check("stop_note", 32'(cur_note), 0);
        tick();
        check("stop_audio_en", 32'(audio_en), 0);
        loop_en = 1'b0;

        // Pause in the middle of note 6 (address 2, tick 1) and resume.
        start_song();
        repeat (15) tick();
        check("pause_pre_note", 32'(cur_note), 6);
        cmd_pause = 1'b1;
        tick();
        cmd_pause = 1'b0;
        tick();
        check("paused_playing", 32'(playing), 0);
        check("paused_audio_en", 32'(audio_en), 0);
        check("paused_addr", 32'(rom_addr), 2);
        check("paused_note", 32'(cur_note), 6);
        check("paused_phase", 32'(dut.phase), 12);
        repeat (4) tick();
        check("paused_phase_hold", 32'(dut.phase), 12);
        cmd_pause = 1'b1;
        tick();
        cmd_pause = 1'b0;
        check("resume_playing", 32'(playing), 1);
        tick();
        check("resume_phase", 32'(dut.phase), 18);
        tick();
        check("resume_addr_hold", 32'(rom_addr), 2);
        tick();
        check("resume_addr_next", 32'(rom_addr), 3);

        // Restart while in FETCH, then an SFX over note 9 (address 3).
        start_song();
        check("restart_addr", 32'(rom_addr), 0);
        check("restart_playing", 32'(playing), 1);
        repeat (20) tick();
        check("sfx_pre_note", 32'(cur_note), 9);
        sfx_req = 1'b1; sfx_note = 8'd50;
        tick();
        sfx_req = 1'b0;
        check("sfx_ack", 32'(sfx_ack), 1);
        check("sfx_phase0", 32'(dut.phase), 9);
        tick();
        check("sfx_ack_pulse", 32'(sfx_ack), 0);
        check("sfx_out_59", 32'(audio_out), 0);
        check("sfx_en", 32'(audio_en), 1);
        tick();
        check("sfx_out_109", 32'(audio_out), 0);
        tick();
        check("sfx_out_159", 32'(audio_out), 1);
        check("sfx_music_addr", 32'(rom_addr), 4);
        tick();
        tick();
        check("sfx_out_wrap", 32'(audio_out), 0);
        check("sfx_music_note", 32'(cur_note), 12);
        tick();
        check("sfx_last_phase", 32'(dut.phase), 53);
        check("sfx_tail_en", 32'(audio_en), 1);
        tick();
        check("music_phase_cont", 32'(dut.phase), 65);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;

        // Retrigger in IDLE on the third active clock; a stop must not cut the SFX.
        repeat (2) tick();
        base_ack = ack_cnt;
        base_en  = en_cnt;
        sfx_req = 1'b1;
        tick();
        sfx_req = 1'b0;
        tick();
        tick();
        sfx_req = 1'b1;
        tick();
        sfx_req = 1'b0;
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        repeat (10) tick();
        check("retrig_acks", 32'(ack_cnt - base_ack), 2);
        check("retrig_len", 32'(en_cnt - base_en), 9);

        // Pause requested during FETCH takes effect on the first PLAY cycle with tick 0.
        start_song();
        cmd_pause = 1'b1;
        tick();
        cmd_pause = 1'b0;
        tick();
        tick();
        check("pend_paused", 32'(playing), 0);
        check("pend_addr", 32'(rom_addr), 0);
        tick();
        cmd_pause = 1'b1;
        tick();
        cmd_pause = 1'b0;
        check("pend_resume", 32'(playing), 1);
        repeat (3) tick();
        check("pend_full_step", 32'(rom_addr), 0);
        tick();
        check("pend_next_addr", 32'(rom_addr), 1);
        tick();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("load_stop_playing", 32'(playing), 0);
        check("load_stop_note", 32'(cur_note), 0);
        check("load_stop_addr", 32'(rom_addr), 0);

        // Start and stop in the same clock: stop wins.
        start_song();
        repeat (4) tick();
        cmd_start = 1'b1; cmd_stop = 1'b1;
        tick();
        cmd_start = 1'b0; cmd_stop = 1'b0;
        check("start_stop_playing", 32'(playing), 0);
        repeat (2) tick();
        check("start_stop_idle", 32'(playing), 0);
        check("start_stop_addr", 32'(rom_addr), 0);

        // Asynchronous reset in the middle of PLAY with an SFX sounding.
        start_song();
        repeat (20) tick();
        sfx_req = 1'b1;
        tick();
        sfx_req = 1'b0;
        tick();
        tick();
        check("prereset_addr", 32'(rom_addr), 3);
        check("prereset_en", 32'(audio_en), 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_addr", 32'(rom_addr), 0);
        check("arst_note", 32'(cur_note), 0);
        check("arst_playing", 32'(playing), 0);
        check("arst_audio_en", 32'(audio_en), 0);
        check("arst_audio_out", 32'(audio_out), 0);
        check("arst_ack", 32'(sfx_ack), 0);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_idle", 32'(playing), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
